// File: rtl/change_dispenser.sv
// Coin-return dispenser: pays a change amount out one coin at a time,
// largest available denomination first (5, 2, 1), skipping empty tubes.
module change_dispenser #(
  parameter int AMT_W        = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             empty_5,
  input  logic             empty_2,
  input  logic             empty_1,
  output logic             eject_5,
  output logic             eject_2,
  output logic             eject_1,
  output logic [AMT_W-1:0] remaining,
  output logic             done,
  output logic             short
);

  localparam int CMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [AMT_W-1:0] D5 = AMT_W'(5);
  localparam logic [AMT_W-1:0] D2 = AMT_W'(2);
  localparam logic [AMT_W-1:0] D1 = AMT_W'(1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AMT_W-1:0] coin;

  // The active solenoid identifies the coin being paid, so no separate register.
  assign coin = eject_5 ? D5 : (eject_2 ? D2 : D1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      eject_5   <= 1'b0;
      eject_2   <= 1'b0;
      eject_1   <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
      short     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            remaining <= req_amount;
            short     <= 1'b0;
            req_ready <= 1'b0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          cnt <= '0;
          if (remaining == '0) begin
            short <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (remaining >= D5 && !empty_5) begin
            eject_5 <= 1'b1;
            state   <= EJECT;
          end else if (remaining >= D2 && !empty_2) begin
            eject_2 <= 1'b1;
            state   <= EJECT;
          end else if (!empty_1) begin
            eject_1 <= 1'b1;
            state   <= EJECT;
          end else begin
            short <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        EJECT: begin
          if (cnt == PULSE_LAST) begin
            eject_5   <= 1'b0;
            eject_2   <= 1'b0;
            eject_1   <= 1'b0;
            remaining <= remaining - coin;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= SELECT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: timeline model checked every cycle, plus
// hand-computed cycle numbers for each directed transaction.
module tb_change_dispenser;

  localparam int AMT_W = 4;
  localparam int P     = 4;
  localparam int G     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             empty_5 = 1'b0;
  logic             empty_2 = 1'b0;
  logic             empty_1 = 1'b0;
  logic             eject_5, eject_2, eject_1;
  logic [AMT_W-1:0] remaining;
  logic             done, short;

  change_dispenser #(.AMT_W(AMT_W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .empty_5(empty_5), .empty_2(empty_2), .empty_1(empty_1),
    .eject_5(eject_5), .eject_2(eject_2), .eject_1(eject_1),
    .remaining(remaining), .done(done), .short(short)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [2:0]       ej;
    logic [AMT_W-1:0] rem;
    logic             done;
    logic             short_f;
    logic             ready;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   live = 1'b0;

  function automatic exp_t mk(input logic [2:0] ej, input int rem, input logic dn,
                              input logic sh, input logic rd);
    exp_t e;
    e.ej      = ej;
    e.rem     = rem[AMT_W-1:0];
    e.done    = dn;
    e.short_f = sh;
    e.ready   = rd;
    return e;
  endfunction

  // Expected per-cycle outputs for a whole request, from the greedy payout rule.
  function automatic void build(input int amt, input logic e5, input logic e2, input logic e1);
    int rem;
    int d;
    logic [2:0] ej;
    rem = amt;
    q.push_back(mk(3'b000, rem, 1'b0, 1'b0, 1'b0));
    while (rem != 0) begin
      if (rem >= 5 && !e5)      d = 5;
      else if (rem >= 2 && !e2) d = 2;
      else if (!e1)             d = 1;
      else                      d = 0;
      if (d == 0) break;
      ej = (d == 5) ? 3'b100 : ((d == 2) ? 3'b010 : 3'b001);
      repeat (P) q.push_back(mk(ej, rem, 1'b0, 1'b0, 1'b0));
      rem = rem - d;
      repeat (G) q.push_back(mk(3'b000, rem, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(3'b000, rem, 1'b0, 1'b0, 1'b0));
    end
    q.push_back(mk(3'b000, rem, 1'b1, rem != 0, 1'b0));
    q.push_back(mk(3'b000, rem, 1'b0, rem != 0, 1'b1));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur <= mk(3'b000, 0, 1'b0, 1'b0, 1'b1);
    end else if (q.size() != 0) begin
      cur <= q.pop_front();
    end else if (cur.ready && req_valid) begin
      build(int'(req_amount), empty_5, empty_2, empty_1);
      cur <= q.pop_front();
    end
    live <= 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      compared++;
      if ({eject_5, eject_2, eject_1} !== cur.ej || remaining !== cur.rem ||
          done !== cur.done || short !== cur.short_f || req_ready !== cur.ready) begin
        mismatched++;
        $display("FAIL model t=%0t ej=%b/%b rem=%0d/%0d done=%b/%b short=%b/%b ready=%b/%b (got/exp)",
                 $time, {eject_5, eject_2, eject_1}, cur.ej, remaining, cur.rem,
                 done, cur.done, short, cur.short_f, req_ready, cur.ready);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  int r_done, r_ready, r_short, r_rem;
  int f5, f2, f1, n5, n2, n1;

  // Runs one request; cycle k is the interval after the k-th edge past acceptance.
  task automatic run(input int amount, input int abort_at, input int max_cyc);
    logic [2:0] prev;
    r_done = -1; r_ready = -1; r_short = -1; r_rem = -1;
    f5 = -1; f2 = -1; f1 = -1; n5 = 0; n2 = 0; n1 = 0;
    @(negedge clk);
    req_amount = amount[AMT_W-1:0];
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    prev = 3'b000;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (abort_at != 0 && k == abort_at) rst = 1'b1;
      if (abort_at != 0 && k == abort_at + 1) begin
        rst = 1'b0;
        check("abort_ejects", int'({eject_5, eject_2, eject_1}), 0);
        check("abort_ready", int'(req_ready), 1);
        check("abort_remaining", int'(remaining), 0);
      end
      if (eject_5 && !prev[2]) begin n5++; if (f5 < 0) f5 = k; end
      if (eject_2 && !prev[1]) begin n2++; if (f2 < 0) f2 = k; end
      if (eject_1 && !prev[0]) begin n1++; if (f1 < 0) f1 = k; end
      prev = {eject_5, eject_2, eject_1};
      if (done && r_done < 0) begin
        r_done = k; r_short = int'(short); r_rem = int'(remaining);
      end
      if (r_done >= 0 && req_ready) begin
        r_ready = k;
        break;
      end
    end
    $display("txn amount=%0d empty=%b%b%b coins5/2/1=%0d/%0d/%0d done_cycle=%0d ready_cycle=%0d short=%0d rem=%0d",
             amount, empty_5, empty_2, empty_1, n5, n2, n1, r_done, r_ready, r_short, r_rem);
  endtask

  initial begin
    int c1, c2, d1, d2, rdy24, rdy25, rem25;
    logic p5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", int'(req_ready), 1);
    check("reset_ejects", int'({eject_5, eject_2, eject_1}), 0);
    check("reset_remaining", int'(remaining), 0);
    check("reset_done", int'(done), 0);

    run(8, 0, 60);
    check("a8_first5", f5, 2);
    check("a8_first2", f2, 9);
    check("a8_first1", f1, 16);
    check("a8_done", r_done, 23);
    check("a8_short", r_short, 0);
    check("a8_rem", r_rem, 0);
    check("a8_ready", r_ready, 24);

    run(0, 0, 20);
    check("a0_coins", n5 + n2 + n1, 0);
    check("a0_done", r_done, 2);
    check("a0_short", r_short, 0);
    check("a0_ready", r_ready, 3);

    empty_5 = 1'b1;
    run(7, 0, 60);
    empty_5 = 1'b0;
    check("e5_n2", n2, 3);
    check("e5_n1", n1, 1);
    check("e5_first1", f1, 23);
    check("e5_done", r_done, 30);
    check("e5_short", r_short, 0);
    check("e5_rem", r_rem, 0);

    empty_2 = 1'b1;
    empty_1 = 1'b1;
    run(8, 0, 40);
    empty_2 = 1'b0;
    empty_1 = 1'b0;
    check("e21_n5", n5, 1);
    check("e21_n21", n2 + n1, 0);
    check("e21_done", r_done, 9);
    check("e21_short", r_short, 1);
    check("e21_rem", r_rem, 3);

    run(9, 10, 18);
    check("abort_first2", f2, 9);
    check("abort_no_done", r_done, -1);

    run(1, 0, 30);
    check("post_abort_first1", f1, 2);
    check("post_abort_done", r_done, 9);
    check("post_abort_short", r_short, 0);

    // req_valid held high across two back-to-back requests.
    c1 = 0; c2 = 0; d1 = -1; d2 = -1; rdy24 = -1; rdy25 = -1; rem25 = -1;
    p5 = 1'b0;
    @(negedge clk);
    req_amount = 4'd15;
    req_valid  = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 30) req_valid = 1'b0;
      if (eject_5 && !p5) begin
        if (k <= 24) c1++; else c2++;
      end
      p5 = eject_5;
      if (done) begin
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 24) rdy24 = int'(req_ready);
      if (k == 25) begin rdy25 = int'(req_ready); rem25 = int'(remaining); end
    end
    $display("txn amount=15 held_valid pulses5=%0d/%0d done_cycles=%0d/%0d", c1, c2, d1, d2);
    check("hold_pulses1", c1, 3);
    check("hold_pulses2", c2, 3);
    check("hold_done1", d1, 23);
    check("hold_done2", d2, 47);
    check("hold_ready24", rdy24, 1);
    check("hold_ready25", rdy25, 0);
    check("hold_rem25", rem25, 15);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-return side of the coffee vending machine. Accepts a change amount in rupees from the vending FSM over a valid/ready handshake.
- Pays the amount out one coin at a time, largest denomination first (5, 2, 1), by pulsing per-denomination ejector solenoids.
- Skips any denomination whose coin tube reports empty. Reports completion, or a shortfall when the amount cannot be paid exactly.

Parameters:
AMT_W, 4, width of the amount and remaining buses (max request 2^AMT_W-1)
PULSE_CYCLES, 4, eject solenoid on-time per coin in clk cycles (>=1)
GAP_CYCLES, 2, settle time after each eject pulse before the next selection (>=1)

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  change request present
req_amount  input  AMT_W  change to return, in rupees
req_ready  output  1  block idle and able to accept a request
empty_5  input  1  Rs5 coin tube empty
empty_2  input  1  Rs2 coin tube empty
empty_1  input  1  Rs1 coin tube empty
eject_5  output  1  Rs5 ejector solenoid drive
eject_2  output  1  Rs2 ejector solenoid drive
eject_1  output  1  Rs1 ejector solenoid drive
remaining  output  AMT_W  amount still owed for the current request
done  output  1  one-cycle pulse: request finished
short  output  1  valid with done: 1 = could not pay remaining exactly

Behaviour:
- Interface: single clock; reset is synchronous and active-high.
- Reset: state=IDLE; req_ready=1; eject_*=0; remaining=0; done=0; short=0. Reset asserted mid-operation aborts the request at the next edge. No partial done is issued and eject outputs drop immediately.
- All outputs are registered. At most one eject_* is high in any cycle.
- States: IDLE, SELECT, EJECT, GAP, DONE.
- IDLE: req_ready=1. Handshake completes on a rising edge with req_valid&&req_ready. At that edge: remaining<=req_amount, go to SELECT. req_amount is sampled only at that edge.
- SELECT (1 cycle, req_ready=0): samples the empty_* inputs.
  - remaining==0: go to DONE with short=0.
  - Otherwise pick the largest d in {5,2,1} with d<=remaining and empty_d==0, then go to EJECT.
  - No eligible denomination: go to DONE with short=1.
- EJECT: eject_d=1 for exactly PULSE_CYCLES consecutive cycles. remaining decrements by d on the edge leaving EJECT. empty_* changes during EJECT are ignored.
- GAP: all eject_*=0 for GAP_CYCLES cycles, then return to SELECT.
- DONE (1 cycle): done=1 and short holds its final value. remaining holds the unpaid residue (0 on success). Next edge returns to IDLE.
- After DONE, short and remaining hold until the next accepted request. short clears on acceptance.
- Arithmetic: the subtraction never underflows because d<=remaining is guaranteed at selection. Widths are unsigned AMT_W. A 5 is chosen only when remaining>=5.
- Latency, request accepted at edge 0 (SELECT occupies cycle 1):
  - Zero amount: done in cycle 2; req_ready back in cycle 3.
  - Each coin adds PULSE_CYCLES+GAP_CYCLES+1 cycles.
- req_valid held while busy is ignored; it is not queued.
- An empty flag that clears later is re-evaluated at each SELECT.

Test Plan:
- Reset, then request amount=8 with all tubes full (P=4, G=2): eject_5 high in cycles 2-5, eject_2 in 9-12, eject_1 in 16-19. done=1 in cycle 23 with short=0, remaining=0. req_ready=1 in cycle 24.
- Request amount=0: no eject pulses; done=1 in cycle 2 with short=0; req_ready=1 in cycle 3.
- empty_5=1, amount=7: ejects 2,2,2,1 in order; done with short=0, remaining=0.
- empty_2=1 and empty_1=1, amount=8: one Rs5 eject, then done with short=1, remaining=3.
- Assert rst for one cycle midway through the second pulse of amount=9:
  - All eject_* low and req_ready=1 the cycle after rst.
  - remaining=0; no done pulse.
  - A following request amount=1 completes normally.
- Hold req_valid high with amount=15 across a whole transaction: second accept occurs only at the first cycle req_ready=1 after done. Exactly three eject_5 pulses per request.
